usb_rst_seq: RTL and testbench

Power-on and software-triggered reset sequencer for the USB host path. Runs in the master clock domain and orders the USB hub reset, the ULPI PHY/wrapper reset and the USB core reset. It releases each reset only after the previous stage has been satisfied, including proof that the PHY's 60 MHz clock is running. It replaces the free-running per-domain reset counters, and its outputs drive `usb_hub_reset_`, the ULPI reset synchroniser and the core's `usb_rst_i`.

---
 rtl/usb_rst_seq_pkg.sv | 45 ++++
 rtl/usb_rst_tgl_det.sv | 19 +
 rtl/usb_rst_seq.sv | 155 +++++++++++++++
 tb/tb_usb_rst_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rst_seq_pkg.sv
// Shared types for the USB reset sequencer: state encoding and the per-state output decode.
package usb_rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    HUB_RST  = 3'd0,
    WAIT_CLK = 3'd1,
    PHY_RST  = 3'd2,
    SETTLE   = 3'd3,
    READY    = 3'd4,
    FAULT    = 3'd5
  } usb_rst_state_e;

  typedef struct packed {
    logic hub_rst_n;
    logic ulpi_rst;
    logic core_rst;
    logic ready;
    logic fault;
  } rst_out_t;

  // Everything held in reset unless the state explicitly releases it.
  function automatic rst_out_t decode_outs(usb_rst_state_e s);
    rst_out_t o;
    o = '{hub_rst_n: 1'b0, ulpi_rst: 1'b1, core_rst: 1'b1, ready: 1'b0, fault: 1'b0};
    case (s)
      WAIT_CLK, PHY_RST: o.hub_rst_n = 1'b1;
      SETTLE: begin
        o.hub_rst_n = 1'b1;
        o.ulpi_rst  = 1'b0;
      end
      READY: begin
        o.hub_rst_n = 1'b1;
        o.ulpi_rst  = 1'b0;
        o.core_rst  = 1'b0;
        o.ready     = 1'b1;
      end
      FAULT:   o.fault = 1'b1;
      default: o.fault = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/usb_rst_tgl_det.sv
// Brings the clk60 divide-by-2 toggle into clk_i and flags each change as a one-cycle pulse.
module usb_rst_tgl_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tgl_i,
  output logic edge_o
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised value.
  logic [2:0] sh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sh <= '0;
    else         sh <= {sh[1:0], tgl_i};
  end

  assign edge_o = sh[2] ^ sh[1];

endmodule

// File: rtl/usb_rst_seq.sv
// USB host reset sequencer: hub -> ULPI PHY -> core, gated on proof that clk60 is running.
// Define USB_RST_SEQ_TIMEOUT_EN to add the clk60 wait timeout, retry count and FAULT state.
module usb_rst_seq
  import usb_rst_seq_pkg::*;
#(
  parameter int HUB_RST_CYCLES = 1200,
  parameter int CLK60_EDGES    = 8,
  parameter int PHY_RST_CYCLES = 16,
  parameter int SETTLE_CYCLES  = 60000,
  parameter int TIMEOUT_CYCLES = 600000,
  parameter int MAX_RETRY      = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sw_rst_i,
  input  logic               clk60_tgl_i,
  output logic               hub_rst_no,
  output logic               ulpi_rst_o,
  output logic               core_rst_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int HUB_W = $clog2(HUB_RST_CYCLES + 1);
  localparam int EDG_W = $clog2(CLK60_EDGES + 1);
  localparam int PHY_W = $clog2(PHY_RST_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [HUB_W-1:0] HUB_TERM = HUB_W'(HUB_RST_CYCLES - 1);
  localparam logic [EDG_W-1:0] EDG_TERM = EDG_W'(CLK60_EDGES - 1);
  localparam logic [PHY_W-1:0] PHY_TERM = PHY_W'(PHY_RST_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_TERM = SET_W'(SETTLE_CYCLES - 1);

  usb_rst_state_e   state, state_n;
  rst_out_t         outs;
  logic             tgl_edge;
  logic             edges_done;
  logic             clr;
  logic [HUB_W-1:0] hub_cnt;
  logic [EDG_W-1:0] edge_cnt;
  logic [PHY_W-1:0] phy_cnt;
  logic [SET_W-1:0] set_cnt;

  usb_rst_tgl_det u_tgl_det (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tgl_i  (clk60_tgl_i),
    .edge_o (tgl_edge)
  );

  assign edges_done = tgl_edge && (edge_cnt == EDG_TERM);

`ifdef USB_RST_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_TERM = RTY_W'(MAX_RETRY);

  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             tmo_fire;
  logic             retry_last;

  // A clk60 proof arriving on the timeout cycle still counts as success.
  assign tmo_fire   = (state == WAIT_CLK) && !edges_done && (tmo_cnt == TMO_TERM);
  assign retry_last = (int'(retry_cnt) + 1 >= MAX_RETRY);

  // Retry history spans rounds, so only sw_rst_i or rst_ni clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 retry_cnt <= '0;
    else if (sw_rst_i)                           retry_cnt <= '0;
    else if (tmo_fire && retry_cnt != RTY_TERM)  retry_cnt <= retry_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_n = state;
    case (state)
      HUB_RST:  if (hub_cnt == HUB_TERM) state_n = WAIT_CLK;
      WAIT_CLK: begin
        if (edges_done) state_n = PHY_RST;
`ifdef USB_RST_SEQ_TIMEOUT_EN
        else if (tmo_fire) state_n = retry_last ? FAULT : HUB_RST;
`endif
      end
      PHY_RST:  if (phy_cnt == PHY_TERM) state_n = SETTLE;
      SETTLE:   if (set_cnt == SET_TERM) state_n = READY;
      default:  state_n = state;
    endcase
    if (sw_rst_i) state_n = HUB_RST;
  end

  // Outputs decode from state_n so they move on the same edge as the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= HUB_RST;
      outs  <= decode_outs(HUB_RST);
    end else begin
      state <= state_n;
      outs  <= decode_outs(state_n);
    end
  end

  // Holding sw_rst_i keeps every counter pinned at zero.
  assign clr = sw_rst_i || (state_n != state);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hub_cnt  <= '0;
      edge_cnt <= '0;
      phy_cnt  <= '0;
      set_cnt  <= '0;
`ifdef USB_RST_SEQ_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else if (clr) begin
      hub_cnt  <= '0;
      edge_cnt <= '0;
      phy_cnt  <= '0;
      set_cnt  <= '0;
`ifdef USB_RST_SEQ_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      case (state)
        HUB_RST: if (hub_cnt != HUB_TERM) hub_cnt <= hub_cnt + 1'b1;
        WAIT_CLK: begin
          if (tgl_edge && edge_cnt != EDG_TERM) edge_cnt <= edge_cnt + 1'b1;
`ifdef USB_RST_SEQ_TIMEOUT_EN
          if (tmo_cnt != TMO_TERM) tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        PHY_RST: if (phy_cnt != PHY_TERM) phy_cnt <= phy_cnt + 1'b1;
        SETTLE:  if (set_cnt != SET_TERM) set_cnt <= set_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign hub_rst_no = outs.hub_rst_n;
  assign ulpi_rst_o = outs.ulpi_rst;
  assign core_rst_o = outs.core_rst;
  assign ready_o    = outs.ready;
  assign state_o    = state;

`ifdef USB_RST_SEQ_TIMEOUT_EN
  assign fault_o = outs.fault;
`else
  logic unused_cfg;
  assign unused_cfg = ^{outs.fault, TIMEOUT_CYCLES, MAX_RETRY};
  assign fault_o    = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rst_seq.sv
// Randomised bench for usb_rst_seq against a phase/duration reference model.
module tb_usb_rst_seq;

  localparam int HUB_N = 10, EDG_N = 4, PHY_N = 3, SET_N = 5, TMO_N = 50, RTY_N = 3;
  localparam logic [7:0] RST_VEC = {5'b01100, 3'd0};

  logic       clk_i = 1'b0, rst_ni = 1'b0, sw_rst_i = 1'b0, clk60_tgl_i = 1'b0;
  logic       hub_rst_no, ulpi_rst_o, core_rst_o, ready_o, fault_o;
  logic [2:0] state_o;

  int checks = 0, errors = 0;
  bit clk60_on = 1'b0;

  // Reference model: phase, time spent in phase, edges seen, retries.
  int m_phase, m_t, m_edges, m_retries, cyc = 0;
  int due[$];
  bit last_tgl;

  usb_rst_seq #(
    .HUB_RST_CYCLES (HUB_N), .CLK60_EDGES (EDG_N), .PHY_RST_CYCLES (PHY_N),
    .SETTLE_CYCLES  (SET_N), .TIMEOUT_CYCLES (TMO_N), .MAX_RETRY (RTY_N)
  ) dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .sw_rst_i (sw_rst_i), .clk60_tgl_i (clk60_tgl_i),
    .hub_rst_no (hub_rst_no), .ulpi_rst_o (ulpi_rst_o), .core_rst_o (core_rst_o),
    .ready_o (ready_o), .fault_o (fault_o), .state_o (state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] dut_vec();
    return {hub_rst_no, ulpi_rst_o, core_rst_o, ready_o, fault_o, state_o};
  endfunction

  function automatic logic [7:0] exp_vec();
    case (m_phase)
      0:       return {5'b01100, 3'd0};
      1:       return {5'b11100, 3'd1};
      2:       return {5'b11100, 3'd2};
      3:       return {5'b10100, 3'd3};
      4:       return {5'b10010, 3'd4};
      default: return {5'b01101, 3'd5};
    endcase
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_t = 0; m_edges = 0; m_retries = 0;
    due.delete();
    last_tgl = 1'b0;
  endfunction

  function automatic void enter(int p);
    m_phase = p; m_t = 0; m_edges = 0;
  endfunction

  // A toggle change sampled at edge k is counted by the sequencer at edge k+2.
  function automatic void model_edge(bit sw, bit tgl);
    bit ev;
    ev = 1'b0;
    if (due.size() > 0 && due[0] == cyc) begin
      ev = 1'b1;
      void'(due.pop_front());
    end
    if (tgl != last_tgl) due.push_back(cyc + 2);
    last_tgl = tgl;
    if (sw) begin
      enter(0);
      m_retries = 0;
      return;
    end
    m_t++;
    case (m_phase)
      0: if (m_t == HUB_N) enter(1);
      1: begin
        if (ev) m_edges++;
        if (m_edges == EDG_N) enter(2);
`ifdef USB_RST_SEQ_TIMEOUT_EN
        else if (m_t == TMO_N) begin
          m_retries++;
          enter(m_retries < RTY_N ? 0 : 5);
        end
`endif
      end
      2: if (m_t == PHY_N) enter(3);
      3: if (m_t == SET_N) enter(4);
      default: ;
    endcase
  endfunction

  task automatic step();
    if (clk60_on && $urandom_range(0, 1) == 1) clk60_tgl_i = ~clk60_tgl_i;
    @(posedge clk_i);
    cyc++;
    if (!rst_ni) model_reset();
    else         model_edge(sw_rst_i, clk60_tgl_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) step();
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), RST_VEC);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_power_on();
    int hub_rise, ulpi_fall, rdy_at;
    hub_rise = -1; ulpi_fall = -1; rdy_at = -1;
    clk60_on = 1'b1;
    for (int i = 1; i <= 400 && rdy_at < 0; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL power_on cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
      if (hub_rst_no === 1'b1 && hub_rise < 0) hub_rise = i;
      if (ulpi_rst_o === 1'b0 && ulpi_fall < 0) ulpi_fall = i;
      if (ready_o === 1'b1) rdy_at = i;
    end
    checks++;
    if (hub_rise != HUB_N) begin
      errors++; $display("FAIL power_on_hub_rise got %0d exp %0d", hub_rise, HUB_N);
    end
    checks++;
    if (rdy_at < 0 || rdy_at - ulpi_fall != SET_N) begin
      errors++; $display("FAIL power_on_settle got %0d exp %0d", rdy_at - ulpi_fall, SET_N);
    end
  endtask

  task automatic test_sw_rst();
    int rise;
    rise = -1;
    sw_rst_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL sw_hold cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
      if (i == 0) begin
        checks++;
        if ({hub_rst_no, ready_o} !== 2'b00) begin
          errors++; $display("FAIL sw_assert got %b exp 00", {hub_rst_no, ready_o});
        end
      end
    end
    sw_rst_i = 1'b0;
    for (int i = 1; i <= 300 && ready_o !== 1'b1; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL sw_release cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
      if (hub_rst_no === 1'b1 && rise < 0) rise = i;
    end
    checks++;
    if (rise != HUB_N || ready_o !== 1'b1) begin
      errors++; $display("FAIL sw_hub_rise got %0d rdy %b exp %0d rdy 1", rise, ready_o, HUB_N);
    end
  endtask

  task automatic test_sw_vs_settle();
    bit rdy_seen;
    rdy_seen = 1'b0;
    clk60_on = 1'b1;
    sw_rst_i = 1'b1; step(); sw_rst_i = 1'b0;
    for (int i = 0; i < 300 && !(m_phase == 3 && m_t == SET_N - 1); i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL race_run cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
      if (ready_o === 1'b1) rdy_seen = 1'b1;
    end
    sw_rst_i = 1'b1;
    step();
    sw_rst_i = 1'b0;
    if (ready_o === 1'b1) rdy_seen = 1'b1;
    checks++;
    if (state_o !== 3'd0 || rdy_seen) begin
      errors++; $display("FAIL race_sw_wins got state %0d rdy %b exp state 0 rdy 0", state_o, rdy_seen);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL race_model got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_async_rst();
    int c0;
    clk60_on = 1'b1;
    for (int i = 0; i < 300 && !(m_phase == 3 && m_t == 2); i++) step();
    checks++;
    if (state_o !== 3'd3) begin
      errors++; $display("FAIL arst_reach_settle got %0d exp 3", state_o);
    end
    c0 = cyc;
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== RST_VEC || cyc != c0) begin
      errors++; $display("FAIL arst_immediate got %h exp %h", dut_vec(), RST_VEC);
    end
    repeat (2) step();
    rst_ni = 1'b1;
    for (int i = 0; i < 300 && ready_o !== 1'b1; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL arst_restart cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL arst_ready got %b exp 1", ready_o);
    end
  endtask

  task automatic test_clk_stall();
    clk60_on = 1'b0;
    sw_rst_i = 1'b1; step(); sw_rst_i = 1'b0;
`ifdef USB_RST_SEQ_TIMEOUT_EN
    begin
      int rounds;
      logic [2:0] prev;
      rounds = 0; prev = state_o;
      for (int i = 0; i < 1000 && fault_o !== 1'b1; i++) begin
        step();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL stall_tmo cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
        end
        if (state_o == 3'd1 && prev != 3'd1) rounds++;
        prev = state_o;
      end
      checks++;
      if (rounds != RTY_N || fault_o !== 1'b1 || state_o !== 3'd5) begin
        errors++; $display("FAIL stall_fault got rounds %0d fault %b exp rounds %0d fault 1", rounds, fault_o, RTY_N);
      end
      sw_rst_i = 1'b1; step(); sw_rst_i = 1'b0;
      checks++;
      if (fault_o !== 1'b0 || state_o !== 3'd0) begin
        errors++; $display("FAIL fault_clear got fault %b state %0d exp 0 0", fault_o, state_o);
      end
    end
`else
    for (int i = 0; i < 10000 + HUB_N + 4; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_wait cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (state_o !== 3'd1 || fault_o !== 1'b0) begin
      errors++; $display("FAIL stall_hold got state %0d fault %b exp 1 0", state_o, fault_o);
    end
`endif
    clk60_on = 1'b1;
    for (int i = 0; i < 400 && ready_o !== 1'b1; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_resume cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL stall_ready got %b exp 1", ready_o);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int len, sw_len;
      clk60_on = ($urandom_range(0, 3) != 0);
      sw_len   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      len      = $urandom_range(20, 150);
      for (int i = 0; i < len; i++) begin
        sw_rst_i = (i < sw_len);
        step();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL random it %0d cyc %0d got %h exp %h", it, cyc, dut_vec(), exp_vec());
        end
      end
      sw_rst_i = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_on();
    test_sw_rst();
    test_sw_vs_settle();
    test_async_rst();
    test_clk_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
